// File: rtl/data_memory_param_if.sv
// Request/response bus between the data cache controller and data_memory_param.
// The cache side uses the master modport and the memory model uses the slave modport.
interface data_memory_param_if #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned WORDS = LINE_W / 32;

    logic              enable_i;
    logic              write_i;
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic [WORDS-1:0]  mask_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              err_o;
    logic              busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i, mask_i,
        input  ack_o, data_o, err_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i, mask_i,
        output ack_o, data_o, err_o, busy_o
    );
endinterface

// File: rtl/data_memory_param.sv
// Off-chip data-memory model: one line read/write per request, fixed LATENCY, range error, busy.
// Optional per-word write mask is enabled by defining DMEM_WMASK_EN.
module data_memory_param #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 10
) (
    input logic                clk_i,
    input logic                rst_i,
    data_memory_param_if.slave bus
);
    localparam int unsigned OFFS  = $clog2(LINE_W / 8);
    localparam int unsigned WORDS = LINE_W / 32;
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic [LINE_W-1:0] mem_q [DEPTH];

    logic              accept_c, finish_c, in_range_c, mem_we_c, req_write_c;
    logic [ADDR_W-1:0] req_addr_c, line_idx_c;
    logic [LINE_W-1:0] req_data_c, wr_line_c, old_line_c;
    logic [IDX_W-1:0]  mem_idx_c;

    // With LATENCY == 1 the finishing edge is also the accept edge, so use the live inputs in IDLE.
    assign req_addr_c  = (state_q == S_IDLE) ? bus.addr_i  : addr_q;
    assign req_data_c  = (state_q == S_IDLE) ? bus.data_i  : wdata_q;
    assign req_write_c = (state_q == S_IDLE) ? bus.write_i : write_q;

    assign line_idx_c = req_addr_c >> OFFS;
    assign in_range_c = (64'(line_idx_c) < 64'(DEPTH));
    assign mem_idx_c  = IDX_W'(line_idx_c);
    assign old_line_c = mem_q[mem_idx_c];
    assign mem_we_c   = finish_c & in_range_c & req_write_c;

`ifdef DMEM_WMASK_EN
    logic [WORDS-1:0] mask_q, mask_d, req_mask_c;

    assign req_mask_c = (state_q == S_IDLE) ? bus.mask_i : mask_q;

    always_comb begin
        mask_d = mask_q;
        if (accept_c) mask_d = bus.mask_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) mask_q <= '0;
        else        mask_q <= mask_d;
    end

    // Merge selected words of the request into the stored line.
    always_comb begin
        wr_line_c = old_line_c;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (req_mask_c[w]) wr_line_c[w*32 +: 32] = req_data_c[w*32 +: 32];
        end
    end
`else
    logic unused_mask_c;
    assign unused_mask_c = ^bus.mask_i;
    assign wr_line_c     = req_data_c;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        accept_c = 1'b0;
        finish_c = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.enable_i) begin
                    accept_c = 1'b1;
                    addr_d   = bus.addr_i;
                    wdata_d  = bus.data_i;
                    write_d  = bus.write_i;
                    cnt_d    = CNT_W'(1);
                    busy_d   = 1'b1;
                    if (LATENCY > 1) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_ACK;
                        finish_c = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY)) begin
                    state_d  = S_ACK;
                    finish_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish_c) begin
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            err_d   = ~in_range_c;
            rdata_d = in_range_c ? (req_write_c ? wr_line_c : old_line_c) : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory image is intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) mem_q[mem_idx_c] <= wr_line_c;
    end

    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;
    assign bus.busy_o = busy_q;
    assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench for data_memory_param: random and directed requests against a line-array model,
// plus a LATENCY=1 instance for back-to-back spacing.
module tb_data_memory_param;
    localparam int unsigned LINE_W  = 256;
    localparam int unsigned DEPTH   = 512;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LATENCY = 10;
    localparam int unsigned WORDS   = LINE_W / 32;
    localparam time         HALF    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #HALF clk = ~clk;

    data_memory_param_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
    data_memory_param #(.LINE_W(LINE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY))
        dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    data_memory_param_if #(.LINE_W(32), .ADDR_W(8)) bus1 ();
    data_memory_param #(.LINE_W(32), .DEPTH(16), .ADDR_W(8), .LATENCY(1))
        dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1));

    typedef struct {
        logic [LINE_W-1:0] data;
        logic              err;
        time               t;
    } exp_t;

    exp_t              exp_q[$];
    logic [LINE_W-1:0] ref_mem [int];
    int                lines[$];
    int                n_vec = 0;
    int                n_err = 0;
    logic [LINE_W-1:0] last_data = '0;

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < int'(WORDS); w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.ack_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack at %0t expected none", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_data", bus.data_o, e.data);
                check("ack_err", LINE_W'(bus.err_o), LINE_W'(e.err));
                check("ack_time", LINE_W'($time - HALF), LINE_W'(e.t));
                check("busy_in_ack", LINE_W'(bus.busy_o), '0);
                last_data = e.data;
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < int'(4 * LATENCY)) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL ack_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check("data_hold", bus.data_o, last_data);
    endtask

    // Drive one request, predict its response from the line model, then scramble the inputs.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] data,
                         input logic [WORDS-1:0] mask, input bit poke_busy);
        exp_t              e;
        int                idx;
        logic [LINE_W-1:0] line;
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = wr;
        bus.addr_i   = addr;
        bus.data_i   = data;
        bus.mask_i   = mask;
        @(posedge clk);
        e.t = $time + LATENCY * 2 * HALF;
        idx = int'(addr >> 5);
        if (idx >= int'(DEPTH)) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            line = ref_mem.exists(idx) ? ref_mem[idx] : '0;
            if (wr) begin
`ifdef DMEM_WMASK_EN
                for (int w = 0; w < int'(WORDS); w++)
                    if (mask[w]) line[w*32 +: 32] = data[w*32 +: 32];
`else
                line = data;
`endif
                if (!ref_mem.exists(idx)) lines.push_back(idx);
                ref_mem[idx] = line;
            end
            e.data = line;
            e.err  = 1'b0;
        end
        exp_q.push_back(e);
        @(negedge clk);
        bus.enable_i = 1'b0;
        bus.write_i  = 1'($urandom);
        bus.addr_i   = $urandom;
        bus.data_i   = rand_line();
        bus.mask_i   = WORDS'($urandom);
        check("busy_after_accept", LINE_W'(bus.busy_o), LINE_W'(1));
        if (poke_busy) begin
            repeat (3) @(negedge clk);
            bus.enable_i = 1'b1;
            @(negedge clk);
            bus.enable_i = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        logic [LINE_W-1:0] old3;
        logic [31:0]       d1;
        bus.enable_i  = 1'b0; bus.write_i  = 1'b0; bus.addr_i  = '0; bus.data_i  = '0; bus.mask_i  = '0;
        bus1.enable_i = 1'b0; bus1.write_i = 1'b0; bus1.addr_i = '0; bus1.data_i = '0; bus1.mask_i = '0;

        repeat (3) @(negedge clk);
        check("rst_ack", LINE_W'(bus.ack_o), '0);
        check("rst_err", LINE_W'(bus.err_o), '0);
        check("rst_busy", LINE_W'(bus.busy_o), '0);
        check("rst_data", bus.data_o, '0);
        rst_n = 1'b1;

        issue(1'b1, 32'h40, {8{32'hA5A5_0001}}, '1, 1'b0);
        issue(1'b0, 32'h40, '0, '0, 1'b0);
        issue(1'b1, 32'h80, rand_line(), '1, 1'b1);
        issue(1'b0, 32'h80, '0, '0, 1'b0);
        issue(1'b1, 32'h0, rand_line(), '1, 1'b0);
        issue(1'b0, 32'(DEPTH << 5), '0, '0, 1'b0);
        issue(1'b1, 32'((DEPTH + 1) << 5), rand_line(), '1, 1'b0);
        issue(1'b0, 32'h0, '0, '0, 1'b0);
        issue(1'b1, 32'h60, {8{32'h1111_1111}}, '1, 1'b0);
        issue(1'b1, 32'h60, {8{32'hFFFF_FFFF}}, 8'b0000_0101, 1'b0);
        issue(1'b0, 32'h60, '0, '0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int r, idx;
            r = int'($urandom_range(0, 9));
            idx = lines[$urandom_range(0, lines.size() - 1)];
            if (r < 3)
                issue(1'b1, 32'($urandom_range(0, 31) << 5) | 32'($urandom_range(0, 31)), rand_line(), '1, 1'b0);
            else if (r < 6)
                issue(1'b1, 32'(idx << 5), rand_line(), WORDS'($urandom), 1'b0);
            else if (r < 9)
                issue(1'b0, 32'(idx << 5) | 32'($urandom_range(0, 31)), '0, '0, 1'b0);
            else
                issue(1'($urandom), 32'((DEPTH + $urandom_range(0, 100)) << 5), rand_line(), '1, 1'b0);
        end

        // Abort a write to line 3 with reset in the middle of its wait.
        issue(1'b1, 32'h60 + 32'h0, rand_line(), '1, 1'b0);
        issue(1'b1, 32'h3 << 5, rand_line(), '1, 1'b0);
        old3 = ref_mem[3];
        @(negedge clk);
        bus.enable_i = 1'b1; bus.write_i = 1'b1; bus.addr_i = 32'h3 << 5; bus.data_i = ~old3; bus.mask_i = '1;
        @(negedge clk);
        bus.enable_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ack", LINE_W'(bus.ack_o), '0);
        check("abort_err", LINE_W'(bus.err_o), '0);
        check("abort_busy", LINE_W'(bus.busy_o), '0);
        check("abort_data", bus.data_o, '0);
        repeat (15) @(negedge clk);
        check("abort_no_ack", LINE_W'(bus.ack_o), '0);
        rst_n = 1'b1;
        last_data = '0;
        repeat (15) @(negedge clk);
        issue(1'b0, 32'h3 << 5, '0, '0, 1'b0);

        // LATENCY=1 instance with enable held high: accepts every second edge.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) check("l1_idle_gap", LINE_W'(bus1.ack_o), '0);
            bus1.enable_i = 1'b1; bus1.write_i = 1'b1; bus1.mask_i = 1'b1;
            bus1.addr_i = 8'(k << 2);
            bus1.data_i = 32'hC0DE_0000 + 32'(k);
            @(negedge clk);
            check("l1_wr_ack", LINE_W'(bus1.ack_o), LINE_W'(1));
            check("l1_wr_data", LINE_W'(bus1.data_o), LINE_W'(32'hC0DE_0000 + 32'(k)));
        end
        for (int k = 5; k >= 0; k--) begin
            @(negedge clk);
            check("l1_idle_gap", LINE_W'(bus1.ack_o), '0);
            bus1.write_i = 1'b0;
            bus1.addr_i  = 8'(k << 2) | 8'(k & 3);
            bus1.data_i  = '0;
            @(negedge clk);
            d1 = 32'hC0DE_0000 + 32'(k);
            check("l1_rd_ack", LINE_W'(bus1.ack_o), LINE_W'(1));
            check("l1_rd_data", LINE_W'(bus1.data_o), LINE_W'(d1));
            check("l1_rd_err", LINE_W'(bus1.err_o), '0);
        end
        @(negedge clk);
        bus1.enable_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
